// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Purpose:
//   Steps through the layers of one SPS pass. For each layer it requests a
//   96-bit code word from the code source, latches the layer fields, launches
//   either the conv engine or the maxpool engine, and waits for that engine to
//   report completion. The pass ends when the source reports it is exhausted
//   or the layer limit is reached. A final pulse rewinds the source.
//
// Parameters:
//   MAXPOOL_CODE  opcode value in code_word[95:80] that selects maxpool
//   MAX_LAYERS    maximum number of code words accepted in one pass
//
// Ports:
//   s_clk          in   clock, all logic on the rising edge
//   s_rst          in   asynchronous active-high reset
//   sps_start      in   single-cycle request to run one pass (IDLE only)
//   code_ready     out  request to the code source, also the accept strobe
//   code_valid     in   code word present on code_word
//   code_word      in   [95:80] opcode, [79:64] bias_scale, [63:48] lif_thrd,
//                       [47:32] in_ch, [31:16] out_ch, [15:0] img_size
//   fetch_done     in   code source exhausted (level)
//   SPS_part_done  out  single-cycle pulse at the end of the pass
//   conv_start     out  single-cycle conv engine launch
//   pool_start     out  single-cycle maxpool engine launch
//   engine_done    in   single-cycle completion pulse from the active engine
//   lyr_*          out  latched fields of the current layer
//   lyr_is_pool    out  1 = current layer is maxpool, 0 = conv
//   layer_idx      out  0-based index of the current layer
//   busy           out  high whenever the sequencer is not idle
//   seq_err        out  sticky flag: pass ended on the layer limit while the
//                       source still had code words
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter logic [15:0] MAXPOOL_CODE = 16'hFFFF,
  parameter int          MAX_LAYERS   = 31
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        sps_start,
  output logic        code_ready,
  input  logic        code_valid,
  input  logic [95:0] code_word,
  input  logic        fetch_done,
  output logic        SPS_part_done,
  output logic        conv_start,
  output logic        pool_start,
  input  logic        engine_done,
  output logic [15:0] lyr_bias_scale,
  output logic [15:0] lyr_lif_thrd,
  output logic [15:0] lyr_in_ch,
  output logic [15:0] lyr_out_ch,
  output logic [15:0] lyr_img_size,
  output logic        lyr_is_pool,
  output logic [4:0]  layer_idx,
  output logic        busy,
  output logic        seq_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LAUNCH,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(MAX_LAYERS - 1);

  // State and registered outputs
  state_t      r_state;
  logic        r_code_ready;
  logic        r_conv_start;
  logic        r_pool_start;
  logic        r_part_done;
  logic        r_busy;
  logic        r_seq_err;
  logic [4:0]  r_layer_idx;
  logic [15:0] r_bias_scale;
  logic [15:0] r_lif_thrd;
  logic [15:0] r_in_ch;
  logic [15:0] r_out_ch;
  logic [15:0] r_img_size;
  logic        r_is_pool;

  // Next-state / next-value terms
  state_t      w_next_state;
  logic        w_accept;
  logic        w_last_layer;
  logic [4:0]  w_layer_idx_next;
  logic        w_seq_err_next;

  // A handshake only counts while the FSM is actually asking for a word, so a
  // source whose valid lingers one cycle past the accept cannot double-load.
  assign w_accept     = (r_state == REQ) && r_code_ready && code_valid;
  assign w_last_layer = (r_layer_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-value logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_layer_idx_next = r_layer_idx;
    w_seq_err_next   = r_seq_err;

    unique case (r_state)
      IDLE: begin
        if (sps_start) begin
          w_layer_idx_next = 5'd0;
          w_next_state     = REQ;
        end
      end

      REQ: begin
        if (w_accept) begin
          w_next_state = LAUNCH;
        end
      end

      LAUNCH: begin
        w_next_state = WAIT;
      end

      WAIT: begin
        if (engine_done) begin
          w_next_state = CHECK;
        end
      end

      CHECK: begin
        if (fetch_done || w_last_layer) begin
          w_next_state = FINISH;
          // Hitting the limit while the source still has words is an overflow.
          if (!fetch_done) begin
            w_seq_err_next = 1'b1;
          end
        end else begin
          w_layer_idx_next = r_layer_idx + 5'd1;
          w_next_state     = REQ;
        end
      end

      FINISH: begin
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // code_ready and busy follow the state being entered, so they are valid for
  // the whole stay in that state. The launch and done pulses are produced
  // while in LAUNCH / FINISH, which places them one cycle after the accepting
  // edge and two cycles after the final engine_done.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_code_ready <= 1'b0;
      r_conv_start <= 1'b0;
      r_pool_start <= 1'b0;
      r_part_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_seq_err    <= 1'b0;
      r_layer_idx  <= 5'd0;
    end else begin
      r_code_ready <= (w_next_state == REQ);
      r_busy       <= (w_next_state != IDLE);
      r_conv_start <= (r_state == LAUNCH) && !r_is_pool;
      r_pool_start <= (r_state == LAUNCH) &&  r_is_pool;
      r_part_done  <= (r_state == FINISH);
      r_seq_err    <= w_seq_err_next;
      r_layer_idx  <= w_layer_idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Layer field capture
  // ---------------------------------------------------------------------------
  // NOTE: these are plain datapath registers, not a memory array, and they
  // drive outputs that must read 0 out of reset, so they take the reset too.
  // Outside an accept they simply hold, including through IDLE.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_bias_scale <= 16'd0;
      r_lif_thrd   <= 16'd0;
      r_in_ch      <= 16'd0;
      r_out_ch     <= 16'd0;
      r_img_size   <= 16'd0;
      r_is_pool    <= 1'b0;
    end else if (w_accept) begin
      r_bias_scale <= code_word[79:64];
      r_lif_thrd   <= code_word[63:48];
      r_in_ch      <= code_word[47:32];
      r_out_ch     <= code_word[31:16];
      r_img_size   <= code_word[15:0];
      r_is_pool    <= (code_word[95:80] == MAXPOOL_CODE);
    end
  end

  assign code_ready     = r_code_ready;
  assign conv_start     = r_conv_start;
  assign pool_start     = r_pool_start;
  assign SPS_part_done  = r_part_done;
  assign busy           = r_busy;
  assign seq_err        = r_seq_err;
  assign layer_idx      = r_layer_idx;
  assign lyr_bias_scale = r_bias_scale;
  assign lyr_lif_thrd   = r_lif_thrd;
  assign lyr_in_ch      = r_in_ch;
  assign lyr_out_ch     = r_out_ch;
  assign lyr_img_size   = r_img_size;
  assign lyr_is_pool    = r_is_pool;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed bench for layer_sequencer. Instance dut_a uses the default
// parameters; instance dut_b uses MAX_LAYERS=2 for the overflow case. Both
// share clock, reset and the code-source/engine inputs; each has its own
// sps_start, and an idle instance ignores the shared inputs. sel chooses
// which instance the observation wires follow.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  logic        s_clk = 1'b0;
  logic        s_rst;
  logic        sps_start;
  logic        sps_start_b;
  logic        code_valid;
  logic [95:0] code_word;
  logic        fetch_done;
  logic        engine_done;
  logic        sel;

  logic        code_ready_a, done_a, conv_a, pool_a, is_pool_a, busy_a, seq_err_a;
  logic [15:0] bias_a, thrd_a, in_a, out_a, img_a;
  logic [4:0]  idx_a;
  logic        code_ready_b, done_b, conv_b, pool_b, is_pool_b, busy_b, seq_err_b;
  logic [15:0] bias_b, thrd_b, in_b, out_b, img_b;
  logic [4:0]  idx_b;

  always #5 s_clk = ~s_clk;

  layer_sequencer dut_a (
    .s_clk(s_clk), .s_rst(s_rst), .sps_start(sps_start),
    .code_ready(code_ready_a), .code_valid(code_valid), .code_word(code_word),
    .fetch_done(fetch_done), .SPS_part_done(done_a),
    .conv_start(conv_a), .pool_start(pool_a), .engine_done(engine_done),
    .lyr_bias_scale(bias_a), .lyr_lif_thrd(thrd_a), .lyr_in_ch(in_a),
    .lyr_out_ch(out_a), .lyr_img_size(img_a), .lyr_is_pool(is_pool_a),
    .layer_idx(idx_a), .busy(busy_a), .seq_err(seq_err_a)
  );

  layer_sequencer #(.MAX_LAYERS(2)) dut_b (
    .s_clk(s_clk), .s_rst(s_rst), .sps_start(sps_start_b),
    .code_ready(code_ready_b), .code_valid(code_valid), .code_word(code_word),
    .fetch_done(fetch_done), .SPS_part_done(done_b),
    .conv_start(conv_b), .pool_start(pool_b), .engine_done(engine_done),
    .lyr_bias_scale(bias_b), .lyr_lif_thrd(thrd_b), .lyr_in_ch(in_b),
    .lyr_out_ch(out_b), .lyr_img_size(img_b), .lyr_is_pool(is_pool_b),
    .layer_idx(idx_b), .busy(busy_b), .seq_err(seq_err_b)
  );

  wire        obs_ready   = sel ? code_ready_b : code_ready_a;
  wire        obs_done    = sel ? done_b       : done_a;
  wire        obs_conv    = sel ? conv_b       : conv_a;
  wire        obs_pool    = sel ? pool_b       : pool_a;
  wire        obs_is_pool = sel ? is_pool_b    : is_pool_a;
  wire        obs_busy    = sel ? busy_b       : busy_a;
  wire [4:0]  obs_idx     = sel ? idx_b        : idx_a;
  wire [79:0] obs_fields  = sel ? {bias_b, thrd_b, in_b, out_b, img_b}
                                : {bias_a, thrd_a, in_a, out_a, img_a};

  int checks   = 0;
  int failures = 0;
  int n_conv   = 0;
  int n_pool   = 0;
  int n_done   = 0;
  int n_acc    = 0;

  // Pulse / handshake counters on the observed instance
  always @(posedge s_clk) begin
    if (obs_conv)               n_conv <= n_conv + 1;
    if (obs_pool)               n_pool <= n_pool + 1;
    if (obs_done)               n_done <= n_done + 1;
    if (obs_ready && code_valid) n_acc <= n_acc + 1;
  end

  function automatic logic [95:0] mk(input logic [15:0] op, bias, thrd, ich, och, img);
    return {op, bias, thrd, ich, och, img};
  endfunction

  localparam logic [95:0] C0 = {16'h0001, 16'h0100, 16'h0040, 16'd3,  16'd48, 16'd32};
  localparam logic [95:0] C1 = {16'h0002, 16'h0200, 16'h0080, 16'd48, 16'd96, 16'd32};
  localparam logic [95:0] P2 = {16'hFFFF, 16'h0000, 16'h0000, 16'd96, 16'd96, 16'd32};

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!obs_ready && n < 10) begin
      tick;
      n++;
    end
    check("ready_rise", obs_ready, 1);
  endtask

  // Source model: valid registered one cycle after ready, held one extra cycle.
  task automatic accept_layer(input logic [95:0] w, input logic exp_pool,
                              input int exp_idx, input logic set_fetch);
    logic [79:0] fields;
    fields = w[79:0];
    wait_ready;
    tick;
    code_valid = 1'b1;
    code_word  = w;
    tick;  // handshake edge has passed
    check("ready_drop", obs_ready, 0);
    check("fields", obs_fields, fields);
    check("is_pool", obs_is_pool, exp_pool);
    check("layer_idx", obs_idx, exp_idx);
    check("busy_run", obs_busy, 1);
    check("start_early", obs_conv | obs_pool, 0);
    tick;  // one cycle after the handshake edge
    check("conv_start", obs_conv, !exp_pool);
    check("pool_start", obs_pool, exp_pool);
    code_valid = 1'b0;
    if (set_fetch) fetch_done = 1'b1;
  endtask

  task automatic end_layer(input logic poke, input logic last);
    tick;
    check("start_len", obs_conv | obs_pool, 0);
    if (sel) sps_start_b = poke;
    else     sps_start   = poke;
    tick;
    sps_start   = 1'b0;
    sps_start_b = 1'b0;
    engine_done = 1'b1;
    tick;
    engine_done = 1'b0;
    if (last) begin
      tick;
      check("done_early", obs_done, 0);
      tick;
      check("part_done", obs_done, 1);
      tick;
      check("done_len", obs_done, 0);
      check("busy_idle", obs_busy, 0);
      check("ready_idle", obs_ready, 0);
      fetch_done = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst       = 1'b0;
    sps_start   = 1'b0;
    sps_start_b = 1'b0;
    code_valid  = 1'b0;
    code_word   = '0;
    fetch_done  = 1'b0;
    engine_done = 1'b0;
    sel         = 1'b0;
    #1 s_rst = 1'b1;
    #2;
    check("rst_ready", obs_ready, 0);
    check("rst_conv", obs_conv, 0);
    check("rst_pool", obs_pool, 0);
    check("rst_done", obs_done, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_seq_err", seq_err_a, 0);
    check("rst_idx", obs_idx, 0);
    check("rst_fields", obs_fields, 0);
    check("rst_is_pool", obs_is_pool, 0);
    check("rst_seq_err_b", seq_err_b, 0);
    repeat (2) @(posedge s_clk);
    #1 s_rst = 1'b0;
    tick;

    // Three-code pass: conv, conv, maxpool; source exhausted after 3rd accept.
    sps_start = 1'b1;
    tick;
    sps_start = 1'b0;
    accept_layer(C0, 1'b0, 0, 1'b0);
    end_layer(1'b0, 1'b0);
    accept_layer(C1, 1'b0, 1, 1'b0);
    end_layer(1'b0, 1'b0);
    accept_layer(P2, 1'b1, 2, 1'b1);
    end_layer(1'b0, 1'b1);
    check("pass1_conv_cnt", n_conv, 2);
    check("pass1_pool_cnt", n_pool, 1);
    check("pass1_done_cnt", n_done, 1);
    check("pass1_acc_cnt", n_acc, 3);
    check("pass1_seq_err", seq_err_a, 0);
    tick;
    tick;
    check("hold_fields", obs_fields, P2[79:0]);
    check("hold_is_pool", obs_is_pool, 1);
    check("hold_img", img_a, 32);

    // Single conv layer (opcode 0001) with sps_start poked during WAIT.
    sps_start = 1'b1;
    tick;
    sps_start = 1'b0;
    accept_layer(C0, 1'b0, 0, 1'b1);
    end_layer(1'b1, 1'b1);
    repeat (3) tick;
    check("no_queue_busy", obs_busy, 0);
    check("no_queue_ready", obs_ready, 0);
    check("pass2_done_cnt", n_done, 2);
    check("pass2_conv_cnt", n_conv, 3);
    check("pass2_acc_cnt", n_acc, 4);

    // Reset during WAIT of layer 1, then a stale engine_done.
    sps_start = 1'b1;
    tick;
    sps_start = 1'b0;
    accept_layer(C0, 1'b0, 0, 1'b0);
    end_layer(1'b0, 1'b0);
    accept_layer(C1, 1'b0, 1, 1'b0);
    tick;
    s_rst = 1'b1;
    #1;
    check("abort_busy", obs_busy, 0);
    check("abort_idx", obs_idx, 0);
    check("abort_fields", obs_fields, 0);
    @(posedge s_clk);
    #1 s_rst = 1'b0;
    engine_done = 1'b1;
    tick;
    engine_done = 1'b0;
    repeat (4) tick;
    check("abort_idle", obs_busy, 0);
    check("abort_ready", obs_ready, 0);
    check("abort_no_done", n_done, 2);
    check("abort_no_start", n_conv + n_pool, 6);

    // MAX_LAYERS=2 instance, source never exhausted: overflow.
    sel = 1'b1;
    tick;
    sps_start_b = 1'b1;
    tick;
    sps_start_b = 1'b0;
    accept_layer(C0, 1'b0, 0, 1'b0);
    end_layer(1'b0, 1'b0);
    accept_layer(C1, 1'b0, 1, 1'b0);
    end_layer(1'b0, 1'b1);
    check("ovf_seq_err", seq_err_b, 1);
    check("ovf_done_cnt", n_done, 3);
    check("ovf_a_clean", seq_err_a, 0);
    // Normal pass afterwards; the flag stays set.
    sps_start_b = 1'b1;
    tick;
    sps_start_b = 1'b0;
    accept_layer(P2, 1'b1, 0, 1'b1);
    end_layer(1'b0, 1'b1);
    check("ovf_sticky", seq_err_b, 1);
    s_rst = 1'b1;
    #1;
    check("ovf_rst_clear", seq_err_b, 0);
    @(posedge s_clk);
    #1 s_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
